transmisor_estado: RTL and testbench
====================================

# transmisor_estado

Serializes a plant-status telemetry frame onto a UART TX line: the return path of the serial link whose receive side feeds `decodificador`. On a one-cycle `enviar` request it snapshots humidity, time, plant type and actuator/module flags, builds a fixed 7-byte frame with header and XOR checksum, and shifts it out 8N1, LSB first. Sits beside `bomba` in `Principal` and shares the system clock.

## Interface
- `DIV`, default 5208: system-clock cycles per UART bit (50 MHz / 9600); minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enviar`  in  1  one-cycle send request.
- `humedad`  in  12  humidity sample.
- `hora`  in  16  time of day.
- `tipoPlanta`  in  4  plant type code.
- `activarB`, `MODbomba`, `MODgrifo`, `MODluz`  in  1 each  pump command and module-present flags.
- `tx`  out  1  UART line; idle high.
- `ocupado`  out  1  high while a frame is in flight.
- `hecho`  out  1  one-cycle pulse when a frame completes.

## Operation
- Frame bytes, in order: B0=0xA5; B1={tipoPlanta, humedad[11:8]}; B2=humedad[7:0]; B3=hora[15:8]; B4=hora[7:0]; B5={4'b0, MODluz, MODgrifo, MODbomba, activarB}; B6=B1^B2^B3^B4^B5 (header excluded).
- Each byte: start bit 0, 8 data bits LSB first, stop bit 1; no inter-byte gap.
- `enviar` accepted only when `ocupado`=0; all inputs captured into a snapshot register on the accepting edge; later input changes do not affect the frame in flight.
- `enviar` while `ocupado`=1: ignored, not queued.
- FSM: IDLE -> START -> DATA (8 bits) -> STOP -> START of next byte, or IDLE after B6's stop bit.
- Counters: bit-period counter 0..DIV-1; bit index 0..7; byte index 0..6. Byte index never exceeds 6.
- Checksum computed from the snapshot, combinationally or at capture; the result is identical.

## Timing
- Reset values: `tx`=1, `ocupado`=0, `hecho`=0, FSM=IDLE, all counters 0. Assertion of `rst_n` mid-frame forces `tx` high immediately and discards the frame.
- `enviar` high at edge E (idle): `ocupado` and start bit (`tx`=0) valid from E+1.
- Every bit held exactly DIV cycles; frame occupies 70·DIV cycles.
- At edge E+1+70·DIV: `ocupado` drops to 0, `hecho` high for exactly that one cycle, `tx`=1.
- `enviar` asserted in the same cycle as `hecho`: accepted, and the next start bit begins the following cycle (back-to-back frames, no idle bit).
- `tx` registered; no combinational path from any input to `tx`.

## Structure
- Shared package `planta_pkg`: `CABECERA`=8'hA5, `N_BYTES`=7, FSM state enum, and field widths (12/16/4) shared with `decodificador`.
- Natural sub-module `uart_tx_byte`: single-byte 8N1 serializer with `DIV` parameter, `cargar`/`dato[7:0]` in, `tx` and `libre` out. `transmisor_estado` owns the snapshot, byte sequencing and checksum.

## Test plan
- Reset: hold `rst_n`=0 -> `tx`=1, `ocupado`=0, `hecho`=0; release -> still idle, no activity for 100 cycles.
- Nominal frame (DIV=4): tipoPlanta=3, humedad=0x2BC, hora=0x1230, activarB=1, MODbomba=1 -> bytes A5 32 BC 12 30 03 AF decoded from `tx`; `hecho` exactly 281 cycles after the `enviar` edge.
- Snapshot: change all inputs 10 cycles after `enviar` -> frame still carries the original values and checksum.
- Busy request: pulse `enviar` mid-frame -> ignored; exactly one frame sent, one `hecho`.
- Back-to-back: `enviar` coincident with `hecho` -> second frame starts next cycle, with no idle bit between the two frames.
- Reset mid-frame: drop `rst_n` during B3 -> `tx`=1 at once; after release, a new `enviar` produces a complete, correct frame.

Source files
------------

// File: rtl/planta_pkg.sv
// Shared plant-status definitions for the telemetry serial link.
// Also used by the receive-side decoder.
package planta_pkg;

  localparam logic [7:0]  CABECERA = 8'hA5;
  localparam int unsigned N_BYTES  = 7;
  localparam int unsigned HUM_W    = 12;
  localparam int unsigned HORA_W   = 16;
  localparam int unsigned TIPO_W   = 4;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;
  typedef enum logic [1:0] {SeqIdle, SeqSend, SeqFin} seq_state_e;

  typedef struct packed {
    logic [TIPO_W-1:0] tipo;
    logic [HUM_W-1:0]  humedad;
    logic [HORA_W-1:0] hora;
    logic              luz;
    logic              grifo;
    logic              bomba;
    logic              activar;
  } snapshot_t;

  // Frame byte idx of a snapshot; the checksum covers bytes 1..5 only.
  function automatic logic [7:0] frame_byte(snapshot_t s, logic [2:0] idx);
    logic [7:0] b1, b2, b3, b4, b5;
    b1 = {s.tipo, s.humedad[11:8]};
    b2 = s.humedad[7:0];
    b3 = s.hora[15:8];
    b4 = s.hora[7:0];
    b5 = {4'b0, s.luz, s.grifo, s.bomba, s.activar};
    case (idx)
      3'd0:    return CABECERA;
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      3'd4:    return b4;
      3'd5:    return b5;
      3'd6:    return b1 ^ b2 ^ b3 ^ b4 ^ b5;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/transmisor_estado_if.sv
// Request/status bundle between the plant controller and the telemetry transmitter.
interface transmisor_estado_if;
  import planta_pkg::*;

  logic              enviar;
  logic [HUM_W-1:0]  humedad;
  logic [HORA_W-1:0] hora;
  logic [TIPO_W-1:0] tipoPlanta;
  logic              activarB;
  logic              MODbomba;
  logic              MODgrifo;
  logic              MODluz;
  logic              tx;
  logic              ocupado;
  logic              hecho;

  modport master (
    output enviar, humedad, hora, tipoPlanta, activarB, MODbomba, MODgrifo, MODluz,
    input  tx, ocupado, hecho
  );

  modport slave (
    input  enviar, humedad, hora, tipoPlanta, activarB, MODbomba, MODgrifo, MODluz,
    output tx, ocupado, hecho
  );

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer, LSB first, DIV clocks per bit.
// libre marks the edges where a new byte may be loaded, including the last stop cycle.
module uart_tx_byte
  import planta_pkg::*;
#(
  parameter int unsigned DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cargar,
  input  logic [7:0] dato,
  output logic       tx,
  output logic       libre
);

  localparam int unsigned    CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            fin_bit;

  assign fin_bit = (cnt_q == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (cargar) begin
          state_d = StStart;
          cnt_d   = '0;
          shift_d = dato;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (fin_bit) begin
          state_d   = StData;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (fin_bit) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (fin_bit) begin
          cnt_d = '0;
          // Chained load keeps consecutive bytes gapless.
          if (cargar) begin
            state_d = StStart;
            shift_d = dato;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    libre = (state_q == StIdle) || ((state_q == StStop) && fin_bit);
  end

  assign tx = tx_q;

endmodule

// File: rtl/transmisor_estado.sv
// Plant-status telemetry transmitter: snapshots inputs on a send request and
// emits a 7-byte header/payload/XOR frame through the byte serializer.
module transmisor_estado
  import planta_pkg::*;
#(
  parameter int unsigned DIV = 5208
) (
  input logic                clk,
  input logic                rst_n,
  transmisor_estado_if.slave bus
);

  localparam logic [2:0] LastIdx = 3'(N_BYTES - 1);

  seq_state_e state_q, state_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  snapshot_t  snap_q, snap_d;
  logic       ocupado_q, ocupado_d;
  logic       hecho_q, hecho_d;
  logic       cargar;
  logic       libre;
  logic [7:0] dato;
  logic       tx;

  uart_tx_byte #(
    .DIV (DIV)
  ) u_uart_tx_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .cargar (cargar),
    .dato   (dato),
    .tx     (tx),
    .libre  (libre)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SeqIdle;
      byte_idx_q <= '0;
      snap_q     <= '0;
      ocupado_q  <= 1'b0;
      hecho_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      snap_q     <= snap_d;
      ocupado_q  <= ocupado_d;
      hecho_q    <= hecho_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;
    unique case (state_q)
      SeqIdle: begin
        if (bus.enviar) begin
          state_d    = SeqSend;
          byte_idx_d = '0;
          snap_d     = {bus.tipoPlanta, bus.humedad, bus.hora,
                        bus.MODluz, bus.MODgrifo, bus.MODbomba, bus.activarB};
        end
      end
      SeqSend: begin
        if (libre) begin
          if (byte_idx_q == LastIdx) begin
            state_d = SeqFin;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      SeqFin: begin
        state_d    = SeqIdle;
        byte_idx_d = '0;
      end
      default: state_d = SeqIdle;
    endcase
  end

  // The header is constant, so the first byte loads on the accepting edge,
  // before the snapshot register has been written.
  always_comb begin
    cargar    = 1'b0;
    dato      = CABECERA;
    ocupado_d = 1'b1;
    hecho_d   = 1'b0;
    unique case (state_q)
      SeqIdle: begin
        cargar    = bus.enviar;
        ocupado_d = bus.enviar;
      end
      SeqSend: begin
        cargar = libre && (byte_idx_q != LastIdx);
        dato   = frame_byte(snap_q, byte_idx_q + 3'd1);
      end
      SeqFin: begin
        ocupado_d = 1'b0;
        hecho_d   = 1'b1;
      end
      default: ocupado_d = 1'b0;
    endcase
  end

  assign bus.tx      = tx;
  assign bus.ocupado = ocupado_q;
  assign bus.hecho   = hecho_q;

endmodule

// File: tb/tb_transmisor_estado.sv
// Directed bench for transmisor_estado: decodes tx at mid-bit and checks frames,
// snapshotting, busy requests, back-to-back frames and reset mid-frame.
module tb_transmisor_estado;

  localparam int unsigned DIV = 4;
  // {B0,...,B6}
  localparam logic [55:0] FrameNom = 56'hA5_32_BC_12_30_03_AF;
  localparam logic [55:0] FrameV2  = 56'hA5_95_A1_C3_7E_0C_85;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   hecho_cnt = 0;

  transmisor_estado_if bus ();

  transmisor_estado #(
    .DIV (DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.hecho === 1'b1) hecho_cnt <= hecho_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_nom();
    bus.tipoPlanta = 4'd3;
    bus.humedad    = 12'h2BC;
    bus.hora       = 16'h1230;
    bus.activarB   = 1'b1;
    bus.MODbomba   = 1'b1;
    bus.MODgrifo   = 1'b0;
    bus.MODluz     = 1'b0;
  endtask

  task automatic set_v2();
    bus.tipoPlanta = 4'd9;
    bus.humedad    = 12'h5A1;
    bus.hora       = 16'hC37E;
    bus.activarB   = 1'b0;
    bus.MODbomba   = 1'b0;
    bus.MODgrifo   = 1'b1;
    bus.MODluz     = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_now(input string tag);
    bus.enviar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.enviar = 1'b0;
    chk({tag, " start tx"}, 32'(bus.tx), 32'd0);
    chk({tag, " start ocupado"}, 32'(bus.ocupado), 32'd1);
  endtask

  // Samples each of the 70 bits mid-period, then checks the completion edge.
  // Returns at the negedge where hecho must be high.
  task automatic run_frame(input string tag, input logic [55:0] exp);
    int pos;
    logic [9:0] sh;
    pos = 0;
    for (int b = 0; b < 7; b++) begin
      for (int j = 0; j < 10; j++) begin
        int k;
        k = b * 10 + j;
        repeat (k * DIV + 1 - pos) @(negedge clk);
        pos = k * DIV + 1;
        sh[j] = bus.tx;
      end
      chk($sformatf("%s B%0d start", tag, b), 32'(sh[0]), 32'd0);
      chk($sformatf("%s B%0d stop", tag, b), 32'(sh[9]), 32'd1);
      chk($sformatf("%s B%0d data", tag, b), 32'(sh[8:1]), 32'(exp[55-8*b -: 8]));
    end
    repeat (70 * DIV - pos) @(negedge clk);
    chk({tag, " hecho early"}, 32'(bus.hecho), 32'd0);
    chk({tag, " ocupado late"}, 32'(bus.ocupado), 32'd1);
    @(negedge clk);
    chk({tag, " hecho"}, 32'(bus.hecho), 32'd1);
    chk({tag, " ocupado end"}, 32'(bus.ocupado), 32'd0);
    chk({tag, " tx end"}, 32'(bus.tx), 32'd1);
  endtask

  task automatic idle_window(input string tag, input int n);
    logic err;
    err = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.ocupado !== 1'b0 || bus.hecho !== 1'b0) err = 1'b1;
    end
    chk(tag, 32'(err), 32'd0);
  endtask

  initial begin
    int h0;
    bus.enviar = 1'b0;
    set_nom();

    // Reset
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(bus.tx), 32'd1);
    chk("rst ocupado", 32'(bus.ocupado), 32'd0);
    chk("rst hecho", 32'(bus.hecho), 32'd0);
    rst_n = 1'b1;
    idle_window("idle after reset", 100);

    // Nominal frame
    h0 = hecho_cnt;
    @(negedge clk);
    start_now("nom");
    run_frame("nom", FrameNom);
    @(negedge clk);
    chk("nom hecho width", 32'(bus.hecho), 32'd0);
    chk("nom hecho count", 32'(hecho_cnt - h0), 32'd1);

    // Inputs change 10 cycles into the frame
    set_nom();
    @(negedge clk);
    start_now("snap");
    fork
      run_frame("snap", FrameNom);
      begin
        repeat (10) @(negedge clk);
        set_v2();
      end
    join
    @(negedge clk);

    // Request while busy is dropped
    h0 = hecho_cnt;
    @(negedge clk);
    start_now("busy");
    fork
      run_frame("busy", FrameV2);
      begin
        repeat (50) @(negedge clk);
        bus.enviar = 1'b1;
        @(negedge clk);
        bus.enviar = 1'b0;
      end
    join
    idle_window("busy no second frame", 100);
    chk("busy hecho count", 32'(hecho_cnt - h0), 32'd1);

    // Back-to-back: request during the hecho cycle
    h0 = hecho_cnt;
    set_nom();
    @(negedge clk);
    start_now("b2b_a");
    run_frame("b2b_a", FrameNom);
    set_v2();
    start_now("b2b_b");
    run_frame("b2b_b", FrameV2);
    @(negedge clk);
    chk("b2b hecho count", 32'(hecho_cnt - h0), 32'd2);

    // Reset during B3, then a clean frame
    set_nom();
    @(negedge clk);
    start_now("mid");
    repeat (130) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst tx", 32'(bus.tx), 32'd1);
    chk("mid rst ocupado", 32'(bus.ocupado), 32'd0);
    chk("mid rst hecho", 32'(bus.hecho), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_window("idle after mid rst", 20);
    set_v2();
    @(negedge clk);
    start_now("post_rst");
    run_frame("post_rst", FrameV2);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
